multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM control unit for the multicycle MIPS datapath. Sequences each instruction
//  through fetch/decode/execute/memory/writeback. Replaces the single-cycle opcode decoder.
//  Holds memory-phase states on a ready handshake, with a watchdog that traps on timeout.
//  Supports R-type, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE, J and JAL.
// PARAMETERS
//  ALUOP_W     3    width of alu_op; codes R=111 ADD=110 OR=101 LUI=100 LW=011 SW=010 AND=001 SUB=000
//  TIMEOUT     15   max cycles waiting for mem_ready before FAULT; 1..255
//  CNT_W       8    width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT
// PORTS
//  clk         in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-high
//  op          in   6        opcode field of the instruction register
//  zero        in   1        ALU zero flag, sampled in BRANCH
//  mem_ready   in   1        memory has completed the current access
//  pc_write    out  1        load PC
//  ir_write    out  1        load instruction register
//  i_or_d      out  1        0 = address from PC, 1 = address from ALUOut
//  mem_read    out  1        memory read strobe
//  mem_write   out  1        memory write strobe
//  mem_to_reg  out  1        1 = write-back data from MDR
//  reg_dst     out  2        00 = rt, 01 = rd, 10 = $31
//  reg_write   out  1        register file write enable
//  alu_src_a   out  1        0 = PC, 1 = rs
//  alu_src_b   out  2        00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
//  alu_op      out  ALUOP_W  ALU function class
//  pc_source   out  2        00 = ALU result, 01 = ALUOut, 10 = jump target
//  fault       out  1        sticky: illegal opcode or memory timeout
//  state       out  4        current state, for debug
// BEHAVIOUR
//  - States: IDLE=0 FETCH=1 DECODE=2 MEM_ADDR=3 MEM_RD=4 MEM_WB=5 MEM_WR=6 EXEC=7 ALU_WB=8
//    BRANCH=9 JUMP=10 FAULT=11. Unused encodings go to IDLE.
//  - Reset: state=IDLE, counter=0, fault=0. All other outputs are 0 while in IDLE.
//  - IDLE -> FETCH unconditionally on the next clock.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
//    ir_write and pc_write are 1 only in the cycle where mem_ready=1; that cycle goes to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target precomputed into ALUOut).
//    Next state by op:
//    - 0x23, 0x2b -> MEM_ADDR
//    - 0x00, 0x08, 0x0d, 0x0c, 0x0f -> EXEC
//    - 0x04, 0x05 -> BRANCH
//    - 0x02, 0x03 -> JUMP
//    - any other op -> FAULT
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next is MEM_RD if op=0x23, else MEM_WR.
//  - MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=00 -> FETCH.
//  - MEM_WR: mem_write=1, i_or_d=1; on mem_ready -> FETCH.
//  - EXEC: alu_src_a=1. R-type: alu_src_b=00, alu_op=111. Immediates: alu_src_b=10,
//    alu_op per opcode code. -> ALU_WB.
//  - ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=01 for R-type else 00 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01.
//    pc_write = (op=0x04 & zero) | (op=0x05 & ~zero) -> FETCH.
//  - JUMP: pc_source=10, pc_write=1. If op=0x03 also reg_write=1 and reg_dst=10;
//    the link value PC+4 is already in PC after FETCH -> FETCH.
//  - Watchdog: counter clears on entry to FETCH, MEM_RD and MEM_WR.
//    It increments each cycle spent in one of those states with mem_ready=0.
//    When counter reaches TIMEOUT with mem_ready still 0 -> FAULT. mem_ready=1 in that
//    same cycle wins and the normal transition is taken.
//  - FAULT: all strobes 0, fault=1, stays there until reset. No pc_write or reg_write
//    ever fires in the cycle that enters FAULT.
//  - Every output is a function of state (and op, zero, mem_ready) only; no output glitches
//    depend on the next state.
//  - Reset asserted mid-instruction forces IDLE immediately and kills all strobes
//    asynchronously.
// TESTING
//  - Reset, then op=0x00, mem_ready held 1: states IDLE,FETCH,DECODE,EXEC,ALU_WB,FETCH;
//    reg_write=1 and reg_dst=01 only in ALU_WB.
//  - LW (op=0x23), mem_ready low 3 cycles in MEM_RD: MEM_RD held 4 cycles, then MEM_WB
//    with mem_to_reg=1. Total 5+3 cycles from FETCH to FETCH.
//  - BEQ: zero=1 gives pc_write=1 with pc_source=01; zero=0 gives pc_write=0.
//    BNE inverted. Both take 3 cycles.
//  - JAL (op=0x03): JUMP state asserts pc_write=1, pc_source=10, reg_write=1, reg_dst=10.
//  - op=0x3f in DECODE: FAULT next, fault=1 sticky; release via reset returns to IDLE
//    with fault=0.
//  - TIMEOUT=15, mem_ready held 0 in FETCH: FAULT after 16 FETCH cycles with no ir_write.
//    mem_ready=1 exactly on cycle 16 instead goes to DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control unit for the multicycle MIPS datapath. It steps each
//   instruction through fetch / decode / execute / memory / writeback.
//   While a memory access is outstanding, the unit holds its state until
//   mem_ready. A watchdog traps to FAULT if the access takes too long.
//   FAULT is left only by reset.
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   op                opcode field of the instruction register
//   zero              ALU zero flag (used in BRANCH)
//   mem_ready         memory has completed the current access
//   pc_write .. pc_source   datapath strobes and mux selects
//   fault             sticky trap indicator (illegal opcode / memory timeout)
//   state             current state encoding, for debug
module multicycle_control #(
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic [1:0]         reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               fault,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC     = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        FAULT    = 4'd11
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(3'b111);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b101);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b000);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    state_t           curState;
    state_t           nextState;
    logic [CNT_W-1:0] wdCnt;
    logic             inWait;
    logic             timedOut;

    assign inWait   = (curState == FETCH) || (curState == MEM_RD) || (curState == MEM_WR);
    assign timedOut = (wdCnt == CNT_W'(TIMEOUT));
    assign state    = curState;

    always_comb begin
        nextState = curState;
        case (curState)
            IDLE:     nextState = FETCH;
            FETCH:    if (mem_ready) nextState = DECODE;
                      else if (timedOut) nextState = FAULT;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:                                 nextState = MEM_ADDR;
                    OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI, OP_LUI:   nextState = EXEC;
                    OP_BEQ, OP_BNE:                               nextState = BRANCH;
                    OP_J, OP_JAL:                                 nextState = JUMP;
                    default:                                      nextState = FAULT;
                endcase
            end
            MEM_ADDR: nextState = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) nextState = MEM_WB;
                      else if (timedOut) nextState = FAULT;
            MEM_WB:   nextState = FETCH;
            MEM_WR:   if (mem_ready) nextState = FETCH;
                      else if (timedOut) nextState = FAULT;
            EXEC:     nextState = ALU_WB;
            ALU_WB:   nextState = FETCH;
            BRANCH:   nextState = FETCH;
            JUMP:     nextState = FETCH;
            FAULT:    nextState = FAULT;
            default:  nextState = IDLE;
        endcase
    end

    // The watchdog counts only while a wait state holds. Any state change
    // clears it, which also covers entry into FETCH, MEM_RD and MEM_WR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curState <= IDLE;
            wdCnt    <= '0;
        end else begin
            curState <= nextState;
            wdCnt    <= (inWait && nextState == curState) ? wdCnt + 1'b1 : '0;
        end
    end

    // Outputs are decoded from the state register only. FETCH also looks
    // at mem_ready, BRANCH at zero, and several states at op. Because of
    // this the asynchronous reset removes every strobe at once, and no
    // strobe depends on nextState.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = '0;
        pc_source  = 2'b00;
        fault      = 1'b0;
        case (curState)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                if (op == OP_RTYPE) begin
                    alu_op = ALU_R;
                end else begin
                    alu_src_b = 2'b10;
                    case (op)
                        OP_ORI:  alu_op = ALU_OR;
                        OP_ANDI: alu_op = ALU_AND;
                        OP_LUI:  alu_op = ALU_LUI;
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (op == OP_RTYPE) ? 2'b01 : 2'b00;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_write  = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
            end
            JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                if (op == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b10;
                end
            end
            FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

endmodule
